// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - coprocessor-0 with SR/Cause/EPC/Count/Compare/PRId, interrupt arbitration and interval timer
module cp0_intc #(
  parameter int          NUM_HWINT = 5,
  parameter int          TIMER_EN  = 1,
  parameter logic [31:0] PRID      = 32'h0000_0001
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic                 EXLClr,
  input  logic [NUM_HWINT-1:0] HWInt,
  output logic [31:0]          EPCOut,
  output logic                 Req
);

  // bits [4:0] are the hardware lines, bit 5 is the timer (register bits 15:10)
  localparam logic [4:0] HW_MASK = 5'((33'd1 << NUM_HWINT) - 33'd1);
  localparam logic [5:0] IM_MASK = {(TIMER_EN != 0), HW_MASK};

  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic        cause_bd;
  logic [4:0]  hw_ip;
  logic        tmr_pend;
  logic [4:0]  cause_exc;
  logic [31:0] epc, count, compare;

  logic [4:0]  hw_ext;
  logic [5:0]  ip;
  logic        int_req, exc_req, wr;
  logic        wr_count, wr_cmp, wr_sr, wr_epc;

  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HWINT-1:0] = HWInt;
  end

  assign ip      = {tmr_pend, hw_ip};
  assign int_req = sr_ie & ~sr_exl & (|(ip & sr_im));
  assign exc_req = ~sr_exl & (ExcCodeIn != 5'd0);
  assign Req     = Reset & (int_req | exc_req);

  // an mtc0 that coincides with handler entry is being flushed, so it is dropped
  assign wr       = En & ~Req;
  assign wr_count = wr & (CP0Add == 5'd9);
  assign wr_cmp   = wr & (CP0Add == 5'd11);
  assign wr_sr    = wr & (CP0Add == 5'd12);
  assign wr_epc   = wr & (CP0Add == 5'd14);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      hw_ip     <= '0;
      tmr_pend  <= 1'b0;
      cause_exc <= '0;
      epc       <= '0;
      count     <= '0;
      compare   <= 32'hFFFF_FFFF;
    end else begin
      hw_ip <= hw_ext;
      count <= wr_count ? CP0In : count + 32'd1;

      if (wr_cmp) begin
        compare  <= CP0In;
        tmr_pend <= 1'b0;
      end else if ((TIMER_EN != 0) && (count == compare)) begin
        tmr_pend <= 1'b1;
      end

      if (wr_sr) begin
        sr_im <= CP0In[15:10] & IM_MASK;
        sr_ie <= CP0In[0];
      end

      if (Req)
        sr_exl <= 1'b1;
      else if (EXLClr)
        sr_exl <= 1'b0;
      else if (wr_sr)
        sr_exl <= CP0In[1];

      if (Req) begin
        cause_bd  <= BDIn;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        epc       <= BDIn ? VPC - 32'd4 : VPC;
      end else if (wr_epc) begin
        epc <= {CP0In[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      5'd9:    CP0Out = count;
      5'd11:   CP0Out = compare;
      5'd12:   CP0Out = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13:   CP0Out = {cause_bd, 15'd0, ip, 3'd0, cause_exc, 2'b00};
      5'd14:   CP0Out = epc;
      5'd15:   CP0Out = PRID;
      default: CP0Out = '0;
    endcase
  end

  assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_intc.sv
// tb/tb_cp0_intc.sv - self-checking bench for cp0_intc
module tb_cp0_intc;

  logic        Clk = 1'b0;
  logic        Reset, En, BDIn, EXLClr, Req;
  logic [4:0]  CP0Add, ExcCodeIn, HWInt;
  logic [31:0] CP0In, CP0Out, VPC, EPCOut;

  int checks = 0;
  int errors = 0;

  cp0_intc #(.NUM_HWINT(5), .TIMER_EN(1), .PRID(32'h0000_0001)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .EXLClr(EXLClr), .HWInt(HWInt), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 Clk = ~Clk;

  // reference state: architectural fields only
  logic [5:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_tip;
  logic [4:0]  m_hwip, m_exc;
  logic [31:0] m_epc, m_count, m_cmp;

  function automatic logic m_intreq();
    return m_ie && !m_exl && ((({m_tip, m_hwip}) & m_im) != 6'd0);
  endfunction

  function automatic logic m_req();
    return Reset && (m_intreq() || (!m_exl && ExcCodeIn != 5'd0));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 5'd9)  r = m_count;
    if (a == 5'd11) r = m_cmp;
    if (a == 5'd12) r = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
    if (a == 5'd13) r = (32'(m_bd) << 31) | (32'({m_tip, m_hwip}) << 10) | (32'(m_exc) << 2);
    if (a == 5'd14) r = m_epc;
    if (a == 5'd15) r = 32'h0000_0001;
    return r;
  endfunction

  task automatic model_edge();
    logic req, intr, w;
    logic [31:0] old_count;
    if (!Reset) begin
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_tip = 0; m_hwip = 0;
      m_exc = 0; m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
    end else begin
      req = m_req();
      intr = m_intreq();
      w = En && !req;
      old_count = m_count;
      m_count = (w && CP0Add == 5'd9) ? CP0In : m_count + 1;
      if (w && CP0Add == 5'd11) begin
        m_cmp = CP0In; m_tip = 0;
      end else if (old_count == m_cmp) begin
        m_tip = 1;
      end
      m_hwip = HWInt;
      if (w && CP0Add == 5'd12) begin
        m_im = CP0In[15:10]; m_exl = CP0In[1]; m_ie = CP0In[0];
      end
      if (EXLClr) m_exl = 0;
      if (w && CP0Add == 5'd14) m_epc = CP0In & ~32'd3;
      if (req) begin
        m_exl = 1;
        m_bd  = BDIn;
        m_exc = intr ? 5'd0 : ExcCodeIn;
        m_epc = BDIn ? VPC - 4 : VPC;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    CP0Add = a;
    #1;
    d = CP0Out;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    En = 1; CP0Add = a; CP0In = d;
    tick();
    En = 0;
  endtask

  typedef struct {
    logic        do_wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t rst_tab[8];
  vec_t wr_tab[8];

  initial begin
    logic [31:0] d;
    logic        found;

    rst_tab[0] = '{1'b0, 5'd9,  32'd0, 32'h0000_0000};
    rst_tab[1] = '{1'b0, 5'd11, 32'd0, 32'hFFFF_FFFF};
    rst_tab[2] = '{1'b0, 5'd12, 32'd0, 32'h0000_0000};
    rst_tab[3] = '{1'b0, 5'd13, 32'd0, 32'h0000_0000};
    rst_tab[4] = '{1'b0, 5'd14, 32'd0, 32'h0000_0000};
    rst_tab[5] = '{1'b0, 5'd15, 32'd0, 32'h0000_0001};
    rst_tab[6] = '{1'b0, 5'd0,  32'd0, 32'h0000_0000};
    rst_tab[7] = '{1'b0, 5'd31, 32'd0, 32'h0000_0000};

    wr_tab[0] = '{1'b1, 5'd11, 32'h8000_0000, 32'h8000_0000};
    wr_tab[1] = '{1'b1, 5'd9,  32'h0000_0100, 32'h0000_0100};
    wr_tab[2] = '{1'b1, 5'd14, 32'h0000_1237, 32'h0000_1234};
    wr_tab[3] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000};
    wr_tab[4] = '{1'b1, 5'd15, 32'hFFFF_FFFF, 32'h0000_0001};
    wr_tab[5] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    wr_tab[6] = '{1'b1, 5'd12, 32'hFFFF_FFFE, 32'h0000_FC02};
    wr_tab[7] = '{1'b1, 5'd12, 32'h0000_0000, 32'h0000_0000};

    Reset = 0; En = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 5'd4; EXLClr = 0; HWInt = 0;
    tick(); tick();
    #1;
    chk("reset_req", 32'(Req), 32'd0);
    chk("reset_epcout", EPCOut, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(rst_tab[i].addr, d);
      chk($sformatf("reset_read_%0d", rst_tab[i].addr), d, rst_tab[i].exp);
      tick();
    end

    Reset = 1; ExcCodeIn = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr(wr_tab[i].addr, wr_tab[i].wdata);
      rd(wr_tab[i].addr, d);
      chk($sformatf("wr_read_%0d_%0d", i, wr_tab[i].addr), d, wr_tab[i].exp);
    end

    // exception entry from a delay slot
    ExcCodeIn = 5'd12; VPC = 32'h3008; BDIn = 1;
    #1;
    chk("exc_req", 32'(Req), 32'd1);
    tick();
    ExcCodeIn = 0; BDIn = 0;
    #1;
    chk("exc_epc", EPCOut, 32'h3004);
    chk("exc_req_drop", 32'(Req), 32'd0);
    rd(5'd13, d); chk("exc_cause", d, 32'h8000_0030);
    rd(5'd12, d); chk("exc_sr", d, 32'h0000_0002);
    EXLClr = 1;
    tick();
    EXLClr = 0;
    rd(5'd12, d); chk("eret_sr", d, 32'h0000_0000);

    // interrupt wins over a simultaneous exception
    wr(5'd12, 32'h0000_0401);
    HWInt = 5'd1;
    tick();
    ExcCodeIn = 5'd10; VPC = 32'h4000;
    #1;
    chk("prio_req", 32'(Req), 32'd1);
    tick();
    ExcCodeIn = 0;
    rd(5'd13, d); chk("prio_cause", d, 32'h0000_0400);
    chk("prio_epc", EPCOut, 32'h4000);
    HWInt = 0; EXLClr = 1;
    tick();
    EXLClr = 0;

    // masked line, then unmasked by mtc0
    wr(5'd12, 32'h0000_0001);
    HWInt = 5'd1;
    tick(); tick();
    #1;
    chk("mask_req", 32'(Req), 32'd0);
    wr(5'd12, 32'h0000_0401);
    #1;
    chk("unmask_req", 32'(Req), 32'd1);
    HWInt = 0;
    tick();
    wr(5'd12, 32'h0000_0000);

    // timer
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    wr(5'd12, 32'h0000_8001);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      #1;
      if (Req) found = 1;
      else tick();
    end
    chk("timer_req_seen", 32'(found), 32'd1);
    rd(5'd9, d);  chk("timer_count", d, 32'd6);
    rd(5'd13, d); chk("timer_ip", d, 32'h0000_8000);
    tick();
    rd(5'd13, d); chk("timer_ip_held", d, 32'h0000_8000);
    rd(5'd12, d); chk("timer_sr", d, 32'h0000_8003);
    wr(5'd11, 32'h7FFF_FFFF);
    rd(5'd13, d); chk("timer_ip_clr", d, 32'h0000_0000);
    wr(5'd12, 32'h0000_0000);
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, d); chk("count_max", d, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, d); chk("count_wrap", d, 32'h0000_0000);

    // mtc0 to EPC flushed by handler entry
    ExcCodeIn = 5'd8; VPC = 32'h5000; BDIn = 0;
    En = 1; CP0Add = 5'd14; CP0In = 32'h1234;
    #1;
    chk("coll_req", 32'(Req), 32'd1);
    tick();
    En = 0; ExcCodeIn = 0;
    #1;
    chk("coll_epc", EPCOut, 32'h5000);

    // reset while in the handler
    Reset = 0;
    tick();
    Reset = 1;
    rd(5'd12, d); chk("midreset_sr", d, 32'h0000_0000);
    rd(5'd13, d); chk("midreset_cause", d, 32'h0000_0000);

    // randomized traffic against the reference
    for (int k = 0; k < 400; k++) begin
      Reset  = ($urandom_range(0, 49) != 0);
      En     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0: CP0Add = 5'd9;
        1: CP0Add = 5'd11;
        2: CP0Add = 5'd12;
        3: CP0Add = 5'd13;
        4: CP0Add = 5'd14;
        5: CP0Add = 5'd15;
        default: CP0Add = 5'($urandom);
      endcase
      CP0In = (CP0Add == 5'd11 && $urandom_range(0, 1) == 1) ?
              m_count + $urandom_range(0, 6) : $urandom;
      VPC       = $urandom & ~32'd3;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      EXLClr    = ($urandom_range(0, 3) == 0);
      HWInt     = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'd0;
      #1;
      chk("rand_req", 32'(Req), 32'(m_req()));
      chk("rand_epc", EPCOut, m_epc);
      chk($sformatf("rand_read_%0d", CP0Add), CP0Out, m_read(CP0Add));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
